// File: rtl/scan_pkg.sv
// Shared helpers for the scanned display multiplexer: width derivation and
// the inactive (all-ones) anode level.
package scan_pkg;

  // Ceiling log2 for elaboration-time width sizing.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Counter/index width for a modulus of n; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Anode enables are active-low, so a dark digit drives this level.
  localparam logic AN_OFF = 1'b1;

endpackage

// File: rtl/scan_mux_tick_gen.sv
// Slot prescaler: counts 0..DIV-1 while enabled and flags the last cycle.
module tick_gen
  import scan_pkg::*;
#(
  parameter int unsigned DIV  = 50000,
  localparam int unsigned CW  = sel_w(DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tick
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Slot end only counts while enabled, so dropping en on that cycle holds everything.
  always_comb begin
    tick  = en && (cnt_q == CW'(DIV - 1));
    cnt_d = cnt_q;
    if (tick)    cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/scan_mux.sv
// Time-multiplexed CH x N selector with internal refresh scanning.
// Optional macro SCAN_MUX_GHOST_BLANK_EN: blank all anodes for the first
// DEAD counts of every slot (anti-ghosting); f is unaffected.
module scan_mux
  import scan_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned CH    = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned DEAD  = 2,
  localparam int unsigned SEL_W = sel_w(CH),
  localparam int unsigned CW    = sel_w(DIV)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [CH*N-1:0]   x,
  input  logic [CH-1:0]     blank_mask,
  output logic [N-1:0]      f,
  output logic [SEL_W-1:0]  sel,
  output logic [CH-1:0]     an,
  output logic              frame_tick
);

  logic [CW-1:0]    cnt;
  logic             slot_end;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N-1:0]     f_q, f_d;
  logic [CH-1:0]    an_q, an_d;
  logic             frame_tick_q, frame_tick_d;
  logic             dead;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .cnt   (cnt),
    .tick  (slot_end)
  );

`ifdef SCAN_MUX_GHOST_BLANK_EN
  assign dead = (cnt < CW'(DEAD));
`else
  logic unused_cfg;
  assign dead       = 1'b0;
  assign unused_cfg = ^cnt ^ (DEAD != 0);
`endif

  // Channel advance, data pick-up and anode decode; all registered from current sel.
  always_comb begin
    sel_d        = sel_q;
    frame_tick_d = 1'b0;
    if (slot_end) begin
      frame_tick_d = (sel_q == SEL_W'(CH - 1));
      sel_d        = frame_tick_d ? '0 : sel_q + 1'b1;
    end

    // Loop over real channels only, so non-power-of-two CH never indexes past x.
    f_d  = '0;
    an_d = {CH{AN_OFF}};
    for (int unsigned k = 0; k < CH; k++) begin
      if (sel_q == SEL_W'(k)) f_d = x[k*N +: N];
      an_d[k] = (sel_q != SEL_W'(k)) || blank_mask[k];
    end
    if (!en || dead) an_d = {CH{AN_OFF}};
  end

  // Output and scan-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q        <= '0;
      f_q          <= '0;
      an_q         <= {CH{AN_OFF}};
      frame_tick_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      f_q          <= f_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign f          = f_q;
  assign sel        = sel_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: three instances (CH=4/DIV=3, CH=3/DIV=1, CH=4/DIV=5)
// share inputs; expectations come from an enabled-cycle count per instance.
module tb_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] x;
  logic [3:0]  mask;

  logic [3:0] f_a, f_b, f_c;
  logic [1:0] sel_a, sel_b, sel_c;
  logic [3:0] an_a, an_c;
  logic [2:0] an_b;
  logic       ft_a, ft_b, ft_c;

  int checks = 0;
  int errors = 0;

  int unsigned chv  [3] = '{4, 3, 4};
  int unsigned divv [3] = '{3, 1, 5};
  int unsigned deadv[3] = '{2, 0, 2};
  int unsigned ecnt [3];

`ifdef SCAN_MUX_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  always #5 clk = ~clk;

  scan_mux #(.N(4), .CH(4), .DIV(3), .DEAD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .blank_mask(mask),
    .f(f_a), .sel(sel_a), .an(an_a), .frame_tick(ft_a));

  scan_mux #(.N(4), .CH(3), .DIV(1), .DEAD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x[11:0]), .blank_mask(mask[2:0]),
    .f(f_b), .sel(sel_b), .an(an_b), .frame_tick(ft_b));

  scan_mux #(.N(4), .CH(4), .DIV(5), .DEAD(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .blank_mask(mask),
    .f(f_c), .sel(sel_c), .an(an_c), .frame_tick(ft_c));

  task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d observed %h expected %h", tag, i, obs, exp);
    end
  endtask

  task automatic get_out(input int i, output logic [15:0] f, output logic [15:0] s,
                         output logic [15:0] a, output logic [15:0] t);
    case (i)
      0:       begin f = 16'(f_a); s = 16'(sel_a); a = 16'(an_a); t = 16'(ft_a); end
      1:       begin f = 16'(f_b); s = 16'(sel_b); a = 16'(an_b); t = 16'(ft_b); end
      default: begin f = 16'(f_c); s = 16'(sel_c); a = 16'(an_c); t = 16'(ft_c); end
    endcase
  endtask

  // One clock with the given inputs; every output of every instance is compared.
  task automatic step(input logic e, input logic [15:0] xv, input logic [3:0] m);
    logic [15:0] ef[3], ean[3], eft[3];
    logic [15:0] of, os, oa, ot;
    int unsigned s, c, all1;
    en = e; x = xv; mask = m;
    for (int i = 0; i < 3; i++) begin
      s    = (ecnt[i] / divv[i]) % chv[i];
      c    = ecnt[i] % divv[i];
      all1 = (1 << chv[i]) - 1;
      ef[i] = 16'((xv >> (s * 4)) & 16'hF);
      if (!e || (GHOST && c < deadv[i])) ean[i] = 16'(all1);
      else ean[i] = 16'((all1 & ~(1 << s)) | (int'(m[s]) << s));
      eft[i] = 16'(e && c == divv[i] - 1 && s == chv[i] - 1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (e) ecnt[i]++;
      get_out(i, of, os, oa, ot);
      chk("f", i, of, ef[i]);
      chk("sel", i, os, 16'((ecnt[i] / divv[i]) % chv[i]));
      chk("an", i, oa, ean[i]);
      chk("frame_tick", i, ot, eft[i]);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    logic [15:0] of, os, oa, ot;
    for (int i = 0; i < 3; i++) begin
      get_out(i, of, os, oa, ot);
      chk({tag, "_f"}, i, of, 16'h0);
      chk({tag, "_sel"}, i, os, 16'h0);
      chk({tag, "_an"}, i, oa, 16'((1 << chv[i]) - 1));
      chk({tag, "_ft"}, i, ot, 16'h0);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; en = 1'b0; x = '0; mask = '0;
    for (int i = 0; i < 3; i++) ecnt[i] = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_reset_state("reset");
    @(negedge clk) rst_n = 1'b1;

    // Continuous scan of a fixed pattern: 24 cycles cover two full frames of inst0.
    for (int k = 0; k < 24; k++) step(1'b1, 16'hDCBA, 4'b0000);

    // Channel 2 blanked during its slot.
    for (int k = 0; k < 15; k++) step(1'b1, 16'hDCBA, 4'b0100);

    // Drop en exactly on an inst0 slot-end cycle, then resume.
    guard = 0;
    while ((ecnt[0] % divv[0]) != divv[0] - 1 && guard < 10) begin
      step(1'b1, 16'h1234, 4'b0000);
      guard++;
    end
    chk("slot_end_reached", 0, 16'(ecnt[0] % divv[0]), 16'(divv[0] - 1));
    for (int k = 0; k < 4; k++) step(1'b0, 16'h5678, 4'b0000);
    for (int k = 0; k < 8; k++) step(1'b1, 16'h9ABC, 4'b0000);

    // Randomised inputs with en mostly high.
    for (int k = 0; k < 300; k++)
      step(($urandom_range(0, 7) != 0), 16'($urandom), 4'($urandom));

    // Asynchronous reset mid-slot with en high, checked before any clock edge.
    step(1'b1, 16'hFEDC, 4'b0000);
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    for (int i = 0; i < 3; i++) ecnt[i] = 0;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 30; k++) step(1'b1, 16'($urandom), 4'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
